// File: rtl/riscv_pkg.sv
// Shared pipeline-control types and constants for the hazard unit.
package riscv_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    // Bubble counts inserted for each kind of load hazard.
    localparam int LOAD_USE_STALL    = 1;
    localparam int LOAD_BRANCH_STALL = 2;

    // Wide enough to hold the longest stall length.
    localparam int STALL_CNT_W = 2;

    // True when a non-x0 destination feeds a source the ID instruction really reads.
    function automatic logic src_match(input logic [4:0] r,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2,
                                       input logic       use1,
                                       input logic       use2);
        return (r != 5'd0) && (((r == rs1) && use1) || ((r == rs2) && use2));
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Free-running event counter: counts enabled cycles, wraps, clears on reset.
module hazard_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count one per enabled cycle; natural wrap at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_count <= '0;
        else if (i_en) r_count <= r_count + CNT_W'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use / load-branch stalls, control flushes,
// memory-wait freeze, plus stall and flush performance counters.
module hazard_control_unit
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_use_rs1,
    input  logic             IF_ID_use_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_mem_read,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             EX_MEM_mem_read,
    input  logic             branch,
    input  logic             jump,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             pipe_freeze,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    hz_state_t              r_state, r_saved_state;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    hz_state_t              w_next_state, w_next_saved, w_eff_state;
    logic [STALL_CNT_W-1:0] w_next_cnt, w_stall_len;
    logic                   w_load_use, w_load_br1, w_load_br2;

    // Hazard terms, only acted upon while in RUN.
    assign w_load_use = ID_EX_mem_read &&
                        src_match(ID_EX_rd, IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2);
    assign w_load_br2 = w_load_use && branch;
    assign w_load_br1 = branch && EX_MEM_mem_read &&
                        src_match(EX_MEM_rd, IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2);

    // Longest applicable stall wins.
    assign w_stall_len = w_load_br2                ? STALL_CNT_W'(LOAD_BRANCH_STALL) :
                         (w_load_use || w_load_br1) ? STALL_CNT_W'(LOAD_USE_STALL)   :
                                                      '0;

    // Leaving MEM_WAIT resumes the saved state in the same cycle.
    assign w_eff_state = (r_state == MEM_WAIT) ? r_saved_state : r_state;

    // State, stall count and saved state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_saved_state <= RUN;
            r_stall_cnt   <= '0;
        end else begin
            r_state       <= w_next_state;
            r_saved_state <= w_next_saved;
            r_stall_cnt   <= w_next_cnt;
        end
    end

    // Next-state and pipeline control; outputs stay idle while reset is held.
    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        pipe_freeze  = 1'b0;
        w_next_state = r_state;
        w_next_saved = r_saved_state;
        w_next_cnt   = r_stall_cnt;
        if (rst_n) begin
            if (mem_busy) begin
                // Freeze everything; remember what we were doing, count holds.
                pipe_freeze  = 1'b1;
                pc_write     = 1'b0;
                IF_ID_write  = 1'b0;
                w_next_state = MEM_WAIT;
                if (r_state != MEM_WAIT) w_next_saved = r_state;
            end else begin
                case (w_eff_state)
                    STALL: begin
                        pc_write    = 1'b0;
                        IF_ID_write = 1'b0;
                        ID_EX_flush = 1'b1;
                        if (r_stall_cnt <= STALL_CNT_W'(1)) begin
                            w_next_state = RUN;
                            w_next_cnt   = '0;
                        end else begin
                            w_next_state = STALL;
                            w_next_cnt   = r_stall_cnt - STALL_CNT_W'(1);
                        end
                    end
                    default: begin
                        w_next_state = RUN;
                        if (w_stall_len != '0) begin
                            pc_write    = 1'b0;
                            IF_ID_write = 1'b0;
                            ID_EX_flush = 1'b1;
                            // This cycle is the first bubble; STALL covers the rest.
                            if (w_stall_len > STALL_CNT_W'(1)) begin
                                w_next_state = STALL;
                                w_next_cnt   = w_stall_len - STALL_CNT_W'(1);
                            end
                        end else begin
                            IF_ID_flush = jump || (branch && branch_taken);
                        end
                    end
                endcase
            end
        end
    end

    assign hz_state = r_state;

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (!pc_write && !pipe_freeze),
        .o_count (stall_cycles)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (IF_ID_flush),
        .o_count (flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench for hazard_control_unit.
module tb_hazard_control_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  IF_ID_rs1 = '0, IF_ID_rs2 = '0, ID_EX_rd = '0, EX_MEM_rd = '0;
    logic        IF_ID_use_rs1 = 1'b0, IF_ID_use_rs2 = 1'b0;
    logic        ID_EX_mem_read = 1'b0, EX_MEM_mem_read = 1'b0;
    logic        branch = 1'b0, jump = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;
    logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze;
    logic [1:0]  hz_state;
    logic [31:0] stall_cycles, flush_count;

    hazard_control_unit #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
        .ID_EX_rd(ID_EX_rd), .ID_EX_mem_read(ID_EX_mem_read),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_mem_read(EX_MEM_mem_read),
        .branch(branch), .jump(jump), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .pipe_freeze(pipe_freeze), .hz_state(hz_state),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] exrd;
        logic       exmr;
        logic [4:0] mrd;
        logic       mmr;
        logic       br, jmp, tkn, busy;
    } in_t;

    typedef struct {
        string       nm;
        logic [4:0]  o;     // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze}
        logic [1:0]  st;
        logic [31:0] sc, fc;
    } exp_t;

    localparam logic [4:0] IDL = 5'b11000;
    localparam logic [4:0] STL = 5'b00010;
    localparam logic [4:0] FRZ = 5'b00001;
    localparam logic [4:0] FLS = 5'b11100;
    localparam in_t        IDLE_IN = '0;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_sc = '0, m_fc = '0;

    function automatic in_t mk(int rs1, int rs2, int u1, int u2, int exrd, int exmr,
                               int mrd, int mmr, int br, int jmp, int tkn, int busy);
        in_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = 1'(u1); v.u2 = 1'(u2);
        v.exrd = 5'(exrd); v.exmr = 1'(exmr); v.mrd = 5'(mrd); v.mmr = 1'(mmr);
        v.br = 1'(br); v.jmp = 1'(jmp); v.tkn = 1'(tkn); v.busy = 1'(busy);
        return v;
    endfunction

    // Drive one cycle of inputs and queue what the outputs must look like in it.
    task automatic cyc(input string nm, input bit rst, input in_t v,
                       input hz_state_t st, input logic [4:0] eo);
        exp_t e;
        @(posedge clk); #1;
        rst_n = rst;
        IF_ID_rs1 = v.rs1; IF_ID_rs2 = v.rs2; IF_ID_use_rs1 = v.u1; IF_ID_use_rs2 = v.u2;
        ID_EX_rd = v.exrd; ID_EX_mem_read = v.exmr;
        EX_MEM_rd = v.mrd; EX_MEM_mem_read = v.mmr;
        branch = v.br; jump = v.jmp; branch_taken = v.tkn; mem_busy = v.busy;
        if (!rst) begin m_sc = '0; m_fc = '0; end
        e.nm = nm; e.o = eo; e.st = st; e.sc = m_sc; e.fc = m_fc;
        q.push_back(e);
        if (rst) begin
            if (!eo[4] && !eo[0]) m_sc = m_sc + 32'd1;
            if (eo[2])            m_fc = m_fc + 32'd1;
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    exp_t        me;
    logic [4:0]  act;
    initial forever begin
        @(negedge clk);
        if (q.size() != 0) begin
            me  = q.pop_front();
            act = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze};
            n_tests++;
            if (act !== me.o || hz_state !== me.st ||
                stall_cycles !== me.sc || flush_count !== me.fc) begin
                n_fail++;
                $display("FAIL %s: got outs=%b st=%0d sc=%0d fc=%0d, want outs=%b st=%0d sc=%0d fc=%0d",
                         me.nm, act, hz_state, stall_cycles, flush_count,
                         me.o, me.st, me.sc, me.fc);
            end
        end
    end

    initial begin
        // Reset held with a hazard present: outputs must still be idle.
        cyc("reset",       0, mk(5,0,1,0, 5,1, 0,0, 0,0,0,0), RUN, IDL);
        // Load-use, single bubble.
        cyc("lu_stall",    1, mk(5,0,1,0, 5,1, 0,0, 0,0,0,0), RUN, STL);
        cyc("lu_done",     1, IDLE_IN,                       RUN, IDL);
        cyc("lu_nouse",    1, mk(5,0,0,0, 5,1, 0,0, 0,0,0,0), RUN, IDL);
        cyc("lu_noload",   1, mk(0,6,0,1, 6,0, 0,0, 0,0,0,0), RUN, IDL);
        // Load feeding a branch from EX: two bubbles, taken ignored meanwhile.
        cyc("lbr2_s1",     1, mk(1,7,1,1, 7,1, 0,0, 1,0,1,0), RUN,   STL);
        cyc("lbr2_s2",     1, mk(1,7,1,1, 7,1, 0,0, 1,0,1,0), STALL, STL);
        cyc("lbr2_res",    1, mk(1,7,1,1, 0,0, 0,0, 1,0,0,0), RUN,   IDL);
        // Load in MEM feeding a branch: one bubble; without a branch: none.
        cyc("lbr1",        1, mk(3,0,1,0, 0,0, 3,1, 1,0,0,0), RUN, STL);
        cyc("lbr1_taken",  1, mk(3,0,1,0, 0,0, 0,0, 1,0,1,0), RUN, FLS);
        cyc("memld_nobr",  1, mk(3,0,1,0, 0,0, 3,1, 0,0,0,0), RUN, IDL);
        // x0 never hazards; jump flushes for one cycle.
        cyc("x0_load",     1, mk(0,0,1,1, 0,1, 0,0, 0,0,0,0), RUN, IDL);
        cyc("jump",        1, mk(0,0,0,0, 0,0, 0,0, 0,1,0,0), RUN, FLS);
        cyc("jump_done",   1, IDLE_IN,                       RUN, IDL);
        // Stall suppresses the jump flush until the stall clears.
        cyc("jmp_lu",      1, mk(2,0,1,0, 2,1, 0,0, 0,1,0,0), RUN, STL);
        cyc("jmp_after",   1, mk(2,0,1,0, 0,0, 2,1, 0,1,0,0), RUN, FLS);
        // mem_busy pre-empts STALL, then the remaining bubble is served.
        cyc("fz_s1",       1, mk(1,7,1,1, 7,1, 0,0, 1,0,0,0), RUN,      STL);
        cyc("fz_b1",       1, mk(1,7,1,1, 7,1, 0,0, 1,0,0,1), STALL,    FRZ);
        cyc("fz_b2",       1, mk(1,7,1,1, 7,1, 0,0, 1,0,0,1), MEM_WAIT, FRZ);
        cyc("fz_b3",       1, mk(1,7,1,1, 7,1, 0,0, 1,0,0,1), MEM_WAIT, FRZ);
        cyc("fz_rem",      1, mk(1,7,1,1, 7,1, 0,0, 1,0,0,0), MEM_WAIT, STL);
        cyc("fz_done",     1, mk(1,7,1,1, 0,0, 0,0, 1,0,0,0), RUN,      IDL);
        // mem_busy blocks a jump flush; leaving MEM_WAIT re-evaluates at once.
        cyc("busy_jmp",    1, mk(0,0,0,0, 0,0, 0,0, 0,1,0,1), RUN,      FRZ);
        cyc("wait_jmp",    1, mk(0,0,0,0, 0,0, 0,0, 0,1,0,0), MEM_WAIT, FLS);
        cyc("wait_done",   1, IDLE_IN,                       RUN,      IDL);
        // Reset in the middle of a two-cycle stall.
        cyc("rs_s1",       1, mk(1,7,1,1, 7,1, 0,0, 1,0,0,0), RUN, STL);
        cyc("rs_rst",      0, mk(1,7,1,1, 7,1, 0,0, 1,0,0,0), RUN, IDL);
        cyc("rs_br",       1, mk(0,0,0,0, 0,0, 0,0, 1,0,1,0), RUN, FLS);
        cyc("rs_idle",     1, IDLE_IN,                       RUN, IDL);
        // Reset in the middle of a freeze.
        cyc("rf_busy",     1, mk(0,0,0,0, 0,0, 0,0, 0,0,0,1), RUN, FRZ);
        cyc("rf_rst",      0, mk(0,0,0,0, 0,0, 0,0, 0,0,0,1), RUN, IDL);
        cyc("rf_rel",      1, IDLE_IN,                       RUN, IDL);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
